// File: rtl/regfile_write_sched.sv
// regfile_write_sched: clears the register file after reset, then round-robins its write port between two requesters
module regfile_write_sched #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              init_done,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_writereg,
  output logic [DATA_W-1:0] rf_writedata
);
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1} state_t;
  localparam logic [ADDR_W:0] SWEEP_END = NUM_REGS[ADDR_W:0];
  state_t state_q;
  logic [ADDR_W:0] cnt_q;
  logic rr_q;
  logic init_done_q, rf_regwrite_q;
  logic [ADDR_W-1:0] rf_writereg_q, sel_reg;
  logic [DATA_W-1:0] rf_writedata_q, sel_data;
  logic run;
  // rr_q low favours A, high favours B when both request
  assign run = state_q == RUN;
  assign a_ready = run && a_valid && (!b_valid || !rr_q);
  assign b_ready = run && b_valid && (!a_valid || rr_q);
  assign sel_reg = a_ready ? a_reg : b_reg;
  assign sel_data = a_ready ? a_data : b_data;
  assign init_done = init_done_q;
  assign rf_regwrite = rf_regwrite_q;
  assign rf_writereg = rf_writereg_q;
  assign rf_writedata = rf_writedata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q <= '0;
      rr_q <= 1'b0;
      init_done_q <= 1'b0;
      rf_regwrite_q <= 1'b0;
      rf_writereg_q <= '0;
      rf_writedata_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == SWEEP_END) begin
            state_q <= RUN;
            rf_regwrite_q <= 1'b0;
            init_done_q <= 1'b1;
          end else begin
            rf_regwrite_q <= 1'b1;
            rf_writereg_q <= cnt_q[ADDR_W-1:0];
            rf_writedata_q <= CLEAR_VAL;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          // a $0 write still consumes the grant but never reaches the regfile
          if (a_ready || b_ready) begin
            rf_regwrite_q <= sel_reg != '0;
            rf_writereg_q <= sel_reg;
            rf_writedata_q <= sel_data;
            rr_q <= a_ready;
          end else begin
            rf_regwrite_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q <= '0;
          init_done_q <= 1'b0;
          rf_regwrite_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_write_sched.sv
// tb_regfile_write_sched: directed stimulus with a timed write scoreboard and a regfile model
module tb_regfile_write_sched;
  logic clk = 0, reset = 1, a_valid = 0, b_valid = 0;
  logic [4:0] a_reg = 0, b_reg = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, init_done, rf_regwrite;
  logic [4:0] rf_writereg;
  logic [31:0] rf_writedata;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {logic [4:0] r; logic [31:0] d; int due;} exp_t;
  exp_t q[$];
  exp_t e_m;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_write_sched dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .init_done(init_done), .rf_regwrite(rf_regwrite),
    .rf_writereg(rf_writereg), .rf_writedata(rf_writedata)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_regwrite === 1'b1) rf[rf_writereg] <= rf_writedata;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("both_ready", {63'd0, a_ready && b_ready}, 64'd0);
    if (rf_regwrite === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg %0d data %0h at cycle %0d, expected no write", rf_writereg, rf_writedata, cyc);
      end else begin
        e_m = q.pop_front();
        chk("wr_reg", 64'(rf_writereg), 64'(e_m.r));
        chk("wr_data", 64'(rf_writedata), 64'(e_m.d));
        chk("wr_cycle", 64'(cyc), 64'(e_m.due));
      end
    end
  end

  task automatic do_reset(int n);
    reset = 1;
    repeat (n) @(posedge clk);
    #1 q.delete();
    reset = 0;
  endtask

  task automatic sweep_expect();
    for (int i = 0; i < 32; i++) q.push_back('{5'(i), 32'h0, cyc + 1 + i});
  endtask

  task automatic wait_init(bit hold_valid);
    int n = 0;
    a_valid = hold_valid;
    b_valid = hold_valid;
    while (!init_done && n < 40) begin
      chk("ready_in_init", 64'({a_ready, b_ready}), 64'd0);
      @(posedge clk);
      #1 n++;
    end
    a_valid = 0;
    b_valid = 0;
    chk("init_cycles", 64'(n), 64'd33);
  endtask

  task automatic check_rf_clear(string t);
    for (int i = 0; i < 32; i++) chk({t, "_rf_clear"}, 64'(rf[i]), 64'd0);
  endtask

  task automatic req(bit av, logic [4:0] ar, logic [31:0] ad, bit bv, logic [4:0] br,
                     logic [31:0] bd, bit ea, bit eb, string nm);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    #1;
    chk({nm, "_a_ready"}, 64'(a_ready), 64'(ea));
    chk({nm, "_b_ready"}, 64'(b_ready), 64'(eb));
    if (ea && ar != 0) q.push_back('{ar, ad, cyc + 1});
    if (eb && br != 0) q.push_back('{br, bd, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    a_valid = 0;
    b_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    foreach (rf[i]) rf[i] = 32'hA5A5A5A5;
    a_valid = 1;
    b_valid = 1;
    @(posedge clk);
    #1;
    chk("rst_regwrite", 64'(rf_regwrite), 64'd0);
    chk("rst_writereg", 64'(rf_writereg), 64'd0);
    chk("rst_writedata", 64'(rf_writedata), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    // T1: clear sweep
    do_reset(2);
    sweep_expect();
    wait_init(1);
    check_rf_clear("t1");
    // T2: single A write and its one-cycle latency
    req(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, "t2");
    chk("t2_regwrite", 64'(rf_regwrite), 64'd1);
    chk("t2_writereg", 64'(rf_writereg), 64'd5);
    chk("t2_writedata", 64'(rf_writedata), 64'hDEADBEEF);
    idle(1);
    chk("t2_idle_regwrite", 64'(rf_regwrite), 64'd0);
    chk("t2_hold_writereg", 64'(rf_writereg), 64'd5);
    chk("t2_hold_writedata", 64'(rf_writedata), 64'hDEADBEEF);
    // B alone moves the pointer back to A
    req(0, 0, 0, 1, 6, 32'h66, 0, 1, "b_only");
    // T3: contention alternates A,B,A,B with B holding while stalled
    req(1, 10, 32'hA0, 1, 20, 32'hB0, 1, 0, "t3c0");
    req(1, 11, 32'hA1, 1, 20, 32'hB0, 0, 1, "t3c1");
    req(1, 11, 32'hA1, 1, 21, 32'hB1, 1, 0, "t3c2");
    req(1, 12, 32'hA2, 1, 21, 32'hB1, 0, 1, "t3c3");
    idle(1);
    // T4: $0 write consumes a grant without writing
    req(1, 8, 32'h88, 0, 0, 0, 1, 0, "t4_a");
    req(0, 0, 0, 1, 0, 32'h1234, 0, 1, "t4_b0");
    chk("t4_no_wr0", 64'(rf_regwrite), 64'd0);
    req(1, 9, 32'h99, 1, 3, 32'h33, 1, 0, "t4_rr");
    idle(2);
    chk("t4_rf0", 64'(rf[0]), 64'd0);
    chk("t4_rf5", 64'(rf[5]), 64'hDEADBEEF);
    chk("t4_rf9", 64'(rf[9]), 64'h99);
    chk("t4_rf11", 64'(rf[11]), 64'hA1);
    chk("t4_rf21", 64'(rf[21]), 64'hB1);
    // T5: reset ten cycles into a sweep restarts it
    do_reset(1);
    chk("t5_done_drop", 64'(init_done), 64'd0);
    sweep_expect();
    repeat (10) @(posedge clk);
    #1;
    chk("t5_mid_done", 64'(init_done), 64'd0);
    do_reset(1);
    chk("t5_regwrite_after_reset", 64'(rf_regwrite), 64'd0);
    sweep_expect();
    wait_init(0);
    check_rf_clear("t5");
    // T6: reset on the accepting edge drops the write
    req(1, 7, 32'h1111, 0, 0, 0, 1, 0, "t6_a");
    idle(1);
    chk("t6_rf7_before", 64'(rf[7]), 64'h1111);
    a_valid = 1; a_reg = 7; a_data = 32'h2222;
    reset = 1;
    #1;
    chk("t6_ready_at_reset", 64'(a_ready), 64'd1);
    @(posedge clk);
    #1 q.delete();
    reset = 0;
    chk("t6_ready_after", 64'(a_ready), 64'd0);
    chk("t6_done_drop", 64'(init_done), 64'd0);
    chk("t6_regwrite_after", 64'(rf_regwrite), 64'd0);
    sweep_expect();
    wait_init(1);
    chk("t6_rf7_cleared", 64'(rf[7]), 64'd0);
    check_rf_clear("t6");
    idle(2);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
